// File: rtl/spi_byte_master.sv
// SPI mode-0 byte engine: shifts one byte out on MOSI (MSB first) while
// shifting one byte in from MISO, with a per-byte programmable half-period.
module spi_byte_master #(
  parameter logic MOSI_IDLE = 1'b1
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        nCS_ctrl,
  input  logic [15:0] clk_div,
  input  logic        wr_req,
  input  logic [7:0]  data_in,
  output logic        wr_ack,
  output logic [7:0]  data_out,
  output logic        DCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        nCS
);

  localparam int unsigned DIV_W     = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned EDGE_W    = 5;
  localparam int unsigned LAST_EDGE = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    div_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [BYTE_W-1:0]   tx_shift;
  logic [BYTE_W-1:0]   rx_shift;
  logic                accept_c;
  logic                tick_c;
  logic                last_c;

  // State register
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus the per-cycle strobes the datapath acts on
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    tick_c   = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          accept_c = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        tick_c = (div_cnt == div_q);
        if (tick_c && DCLK && (edge_cnt == EDGE_W'(LAST_EDGE))) begin
          last_c  = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift datapath, SPI clock generation and completion handshake
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      DCLK     <= 1'b0;
      MOSI     <= MOSI_IDLE;
      wr_ack   <= 1'b0;
      data_out <= '0;
    end else begin
      wr_ack <= last_c;
      if (last_c) begin
        data_out <= rx_shift;
      end
      if (accept_c) begin
        tx_shift <= data_in;
        div_q    <= clk_div;
        MOSI     <= data_in[BYTE_W-1];
        div_cnt  <= '0;
        edge_cnt <= '0;
        DCLK     <= 1'b0;
      end else if (state_q == SHIFT) begin
        if (tick_c) begin
          div_cnt  <= '0;
          DCLK     <= ~DCLK;
          edge_cnt <= edge_cnt + EDGE_W'(1);
          if (!DCLK) begin
            // Rising toggle: capture the card's bit on this same edge
            rx_shift <= {rx_shift[BYTE_W-2:0], MISO};
          end else if (last_c) begin
            MOSI <= MOSI_IDLE;
          end else begin
            // Falling toggle: present the next bit well ahead of the rise
            tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
            MOSI     <= tx_shift[BYTE_W-2];
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else if (state_q == IDLE) begin
        MOSI <= MOSI_IDLE;
        DCLK <= 1'b0;
      end
    end
  end

  // Chip select is a plain one-cycle retime, independent of the FSM
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      nCS <= 1'b1;
    end else begin
      nCS <= nCS_ctrl;
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: directed bytes with a completion scoreboard.
module tb_spi_byte_master;

  logic        sys_clk;
  logic        rst;
  logic        nCS_ctrl;
  logic [15:0] clk_div;
  logic        wr_req;
  logic [7:0]  data_in;
  logic        wr_ack;
  logic [7:0]  data_out;
  logic        DCLK;
  logic        MOSI;
  logic        MISO;
  logic        nCS;

  typedef struct packed {
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests;
  int          fails;
  int unsigned cyc;
  int unsigned ack_cnt;
  int unsigned rise_cnt;
  int unsigned fall_cnt;
  int unsigned card_base;
  logic [7:0]  mosi_seq;
  logic [7:0]  card_byte;
  logic        loop_en;
  logic [2:0]  card_idx;

  spi_byte_master dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .nCS_ctrl (nCS_ctrl),
    .clk_div  (clk_div),
    .wr_req   (wr_req),
    .data_in  (data_in),
    .wr_ack   (wr_ack),
    .data_out (data_out),
    .DCLK     (DCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .nCS      (nCS)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Card model: either loopback, or a fixed byte shifted out on falling DCLK
  assign card_idx = 3'd7 - 3'(fall_cnt - card_base);
  assign MISO     = loop_en ? MOSI : card_byte[card_idx];

  always @(posedge DCLK) begin
    rise_cnt <= rise_cnt + 1;
    mosi_seq <= {mosi_seq[6:0], MOSI};
  end

  always @(negedge DCLK) fall_cnt <= fall_cnt + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every wr_ack pulse is matched against the oldest expectation
  always @(negedge sys_clk) begin
    if (wr_ack === 1'b1) begin
      exp_t e;
      ack_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("ack_data", 32'(data_out), 32'(e.data));
        check("ack_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Present one byte for a single IDLE cycle; returns T0
  task automatic start_byte(input logic [7:0] d, input logic [15:0] div,
                            input int unsigned lat, input logic [7:0] exp,
                            input bit push, output int unsigned t0);
    data_in = d;
    clk_div = div;
    wr_req  = 1'b1;
    t0      = cyc;
    if (push) exp_q.push_back({exp, 32'(t0 + lat)});
    step(1);
    wr_req = 1'b0;
  endtask

  // Wait for ack_cnt to reach target, then step past GAP into IDLE
  task automatic wait_ack(input int unsigned target, input int budget);
    int n;
    n = 0;
    while (ack_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    if (ack_cnt < target) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: got %0d acks expected %0d", ack_cnt, target);
    end
    step(1);
  endtask

  initial begin
    int unsigned t0;
    int unsigned rb;
    int unsigned ab;
    tests     = 0;
    fails     = 0;
    cyc       = 0;
    ack_cnt   = 0;
    rise_cnt  = 0;
    fall_cnt  = 0;
    card_base = 0;
    mosi_seq  = 8'h00;
    card_byte = 8'hFE;
    loop_en   = 1'b1;
    rst       = 1'b0;
    nCS_ctrl  = 1'b1;
    clk_div   = 16'd6;
    wr_req    = 1'b0;
    data_in   = 8'h00;
    step(3);
    rst = 1'b1;
    step(2);

    check("rst_wr_ack", 32'(wr_ack), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_dclk", 32'(DCLK), 32'h0);
    check("rst_mosi", 32'(MOSI), 32'h1);
    check("rst_ncs", 32'(nCS), 32'h1);

    // Loopback A5 at clk_div=6
    rb = rise_cnt;
    start_byte(8'hA5, 16'd6, 113, 8'hA5, 1'b1, t0);
    wait_ack(1, 300);
    check("a5_rises", rise_cnt - rb, 32'd8);
    check("a5_mosi_seq", 32'(mosi_seq), 32'hA5);

    // Card returns FE at clk_div=0
    loop_en   = 1'b0;
    card_base = fall_cnt;
    start_byte(8'h40, 16'd0, 17, 8'hFE, 1'b1, t0);
    wait_ack(2, 100);
    check("fe_dclk_idle", 32'(DCLK), 32'h0);
    check("fe_mosi_idle", 32'(MOSI), 32'h1);
    loop_en = 1'b1;

    // 11 bytes of FF with wr_req held high
    rb      = rise_cnt;
    ab      = ack_cnt;
    data_in = 8'hFF;
    clk_div = 16'd6;
    wr_req  = 1'b1;
    t0      = cyc;
    for (int k = 0; k < 11; k++) exp_q.push_back({8'hFF, 32'(t0 + k * 115 + 113)});
    while (cyc < t0 + 1264) step(1);
    wr_req = 1'b0;
    step(3);
    check("burst_acks", ack_cnt - ab, 32'd11);
    check("burst_rises", rise_cnt - rb, 32'd88);
    check("burst_dclk_idle", 32'(DCLK), 32'h0);

    // clk_div changes mid-byte; takes effect on the next byte only
    start_byte(8'h5A, 16'd6, 113, 8'h5A, 1'b1, t0);
    step(50);
    clk_div = 16'd1;
    wait_ack(ab + 12, 200);
    start_byte(8'hC3, 16'd1, 33, 8'hC3, 1'b1, t0);
    wait_ack(ab + 13, 100);

    // Reset asserted mid-byte (7 toggles done)
    nCS_ctrl = 1'b0;
    step(2);
    ab = ack_cnt;
    start_byte(8'h96, 16'd6, 0, 8'h00, 1'b0, t0);
    while (cyc < t0 + 52) step(1);
    check("pre_rst_ncs", 32'(nCS), 32'h0);
    check("pre_rst_data_out", 32'(data_out), 32'hC3);
    rst = 1'b0;
    #1;
    check("abort_dclk", 32'(DCLK), 32'h0);
    check("abort_mosi", 32'(MOSI), 32'h1);
    check("abort_ncs", 32'(nCS), 32'h1);
    check("abort_wr_ack", 32'(wr_ack), 32'h0);
    check("abort_data_out", 32'(data_out), 32'h00);
    nCS_ctrl = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    start_byte(8'h3C, 16'd2, 49, 8'h3C, 1'b1, t0);
    wait_ack(ab + 1, 150);

    // nCS follows nCS_ctrl one cycle later, with no activity on the bus
    rb = rise_cnt;
    ab = ack_cnt;
    nCS_ctrl = 1'b0;
    @(negedge sys_clk);
    check("ncs_fall_hold", 32'(nCS), 32'h1);
    step(1);
    check("ncs_fall", 32'(nCS), 32'h0);
    step(3);
    nCS_ctrl = 1'b1;
    @(negedge sys_clk);
    check("ncs_rise_hold", 32'(nCS), 32'h0);
    step(1);
    check("ncs_rise", 32'(nCS), 32'h1);
    step(2);
    check("ncs_no_rises", rise_cnt - rb, 32'd0);
    check("ncs_no_acks", ack_cnt - ab, 32'd0);
    check("ncs_dclk", 32'(DCLK), 32'h0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
